spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
SPI mode-0 master that shares one SPI link between NUM_REQ on-chip requesters.
- Arbitrates pending requests, latches the winner's byte and runs one full-duplex 8-bit MSB-first transfer.
- Generates SCLK, SS and MOSI, and captures MISO.
- Returns the received byte and a completion pulse to the granted requester.
- Sits between user logic and the board-level SPI pins (Tang board SPI slave links).

Parameters:
NUM_REQ, 2, number of requesters (1..8)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
DATA_W, 8, bits per transfer

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  level request per requester; held until matching done
req_data  input  NUM_REQ*DATA_W  TX byte per requester, requester i at bits [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot owner of the current transfer, 0 when idle
done  output  1  one-cycle pulse: transfer complete, rx_data valid
rx_data  output  DATA_W  last received byte, held until next done
busy  output  1  high from acceptance through end of GAP
SCLK  output  1  SPI clock, idles low (CPOL=0)
MOSI  output  1  master out, changes while SCLK low
MISO  input  1  slave out
SS  output  1  slave select, active low

Behaviour:
- Reset (async, immediate, including mid-transfer): SS=1, SCLK=0, MOSI=0, grant=0, done=0, busy=0, rx_data=0, arbiter pointer=0, state=IDLE. A partial transfer is abandoned with no done.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP. A divider counter of width clog2(CLK_DIV+1) times every non-IDLE state for exactly CLK_DIV cycles. A 3-bit bit counter counts down from DATA_W-1.
- IDLE: on a clk edge with req!=0, pick a winner and latch its req_data into the shift register. Next cycle: grant=onehot(winner), busy=1, SS=0, MOSI=shift MSB, state SETUP.
- SETUP: SCLK=0, then go to HIGH.
- HIGH: SCLK=1 (slave samples MOSI on the rising edge). On the last HIGH cycle, shift MISO into the rx shift register LSB; SCLK falls on the same edge. If bit counter==0, go to HOLD; otherwise go to LOW.
- LOW: on entry, MOSI=next bit and decrement the bit counter, then go to HIGH.
- HOLD: SCLK=0, SS=0 for CLK_DIV cycles, then go to GAP.
- GAP: SS=1, MOSI=0. On the first GAP cycle, done=1 and rx_data=rx shift register. After CLK_DIV cycles, grant=0 and busy=0, and state returns to IDLE. The next request is accepted no earlier than the IDLE cycle, so minimum SS-high time is CLK_DIV+1 cycles.
- Latency: SS is low for exactly (2*DATA_W+1)*CLK_DIV cycles. done asserts (2*DATA_W+1)*CLK_DIV+1 cycles after the acceptance edge.
- req changes and req_data changes after acceptance are ignored until the next IDLE. Requesters deassert req on or after done. A req still high in the IDLE cycle after GAP is treated as a new request.
- Exactly DATA_W rising SCLK edges per transfer. No glitches on SCLK/SS (both are registered outputs).

Optional Feature:
SPI_ARB_RR_EN
- Defined: round-robin arbitration. Search starts at pointer. Pointer = winner+1 (mod NUM_REQ), updated at acceptance.
- Undefined: fixed priority, lowest index wins. Pointer logic is removed.

Decomposition:
- Package spi_pkg: state encoding (IDLE..GAP), constant DATA_W default, and a clog2 helper for the divider width.
- One natural sub-module: spi_req_arbiter. Combinational select plus registered pointer; inputs req and accept; outputs one-hot winner and index. The FSM, divider and shifters stay in spi_master_arbiter.

Test Plan:
- CLK_DIV=2, req=01, req_data[7:0]=0xA5, slave model returns 0x3C MSB-first. Expect: bench captures 0xA5 on 8 rising SCLK edges; rx_data=0x3C; done 35 cycles after acceptance; SS low 34 cycles.
- Both req=11 held with bytes 0x11/0x22, SPI_ARB_RR_EN defined. Expect grants 0,1,0,1 and MOSI bytes 0x11,0x22,0x11,0x22. Macro undefined: grant 0 every time, requester 1 starved.
- CLK_DIV=1, req=01 continuously. Expect back-to-back transfers with SS high for exactly 2 cycles between them; each SCLK phase is 1 cycle.
- Assert rst during bit 4 of a transfer. Expect SS=1, SCLK=0, grant=0 in the same cycle with no done. After release with req still high, a fresh full transfer runs with 8 SCLK edges.
- req_data changed and req dropped mid-transfer (0xF0 latched, input changed to 0x0F). Expect MOSI still sends 0xF0, done still pulses once, IDLE afterwards.
- MISO held 1 / held 0. Expect rx_data=0xFF / 0x00, and the rx_data value is held stable until the next done.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM state encoding, default
// transfer width and a clog2 helper used to size counters.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_t;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int spi_clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_req_arbiter.sv
// Request arbiter for the SPI master: picks one pending requester per transfer.
// Lowest index wins by default; define SPI_ARB_RR_EN for round-robin from a pointer.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = spi_clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [IDX_W-1:0] low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef SPI_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] up_idx;
  logic             up_found;

  // Lowest requester at or above the pointer; wrap to the lowest overall.
  always_comb begin
    up_idx   = '0;
    up_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) >= ptr)) begin
        up_idx   = IDX_W'(i);
        up_found = 1'b1;
      end
    end
  end

  assign winner_idx = up_found ? up_idx : low_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (winner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx + IDX_W'(1);
    end
  end
`else
  logic unused_rr;
  assign unused_rr  = ^{accept, clk, rst};
  assign winner_idx = low_idx;
`endif

  assign winner = (|req) ? (NUM_REQ'(1) << winner_idx) : '0;

endmodule

// File: rtl/spi_master_arbiter.sv
// SPI mode-0 master shared by NUM_REQ requesters: one full-duplex MSB-first transfer per grant.
// Build option: define SPI_ARB_RR_EN for round-robin arbitration (default fixed priority).
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      SCLK,
  output logic                      MOSI,
  input  logic                      MISO,
  output logic                      SS
);

  localparam int DIV_W = spi_clog2(CLK_DIV + 1);
  localparam int BIT_W = spi_clog2(DATA_W);
  localparam int IDX_W = spi_clog2(NUM_REQ);

  spi_state_t         state, state_d;
  logic [DIV_W-1:0]   div_cnt, div_d;
  logic [BIT_W-1:0]   bit_cnt, bit_d;
  logic [DATA_W-1:0]  tx_shift, tx_d;
  logic [DATA_W-1:0]  rx_shift, rx_d;
  logic [DATA_W-1:0]  rx_q, rx_q_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               sclk_q, sclk_d;
  logic               ss_q, ss_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               div_last;
  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   winner_idx;
  logic [DATA_W-1:0]  sel_data;

  spi_req_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .accept     (accept),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner_idx) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Every state except IDLE lasts CLK_DIV cycles; SPI pins change only on phase boundaries.
  always_comb begin
    state_d = state;
    div_d   = div_last ? '0 : div_cnt + DIV_W'(1);
    bit_d   = bit_cnt;
    tx_d    = tx_shift;
    rx_d    = rx_shift;
    rx_q_d  = rx_q;
    grant_d = grant_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        div_d = '0;
        if (|req) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          grant_d = winner;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          tx_d    = sel_data;
          mosi_d  = sel_data[DATA_W-1];
          bit_d   = BIT_W'(DATA_W - 1);
        end
      end
      ST_SETUP: begin
        if (div_last) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_last) begin
          rx_d   = {rx_shift[DATA_W-2:0], MISO};
          sclk_d = 1'b0;
          if (bit_cnt == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            tx_d    = tx_shift << 1;
            mosi_d  = tx_d[DATA_W-1];
            bit_d   = bit_cnt - BIT_W'(1);
          end
        end
      end
      ST_LOW: begin
        if (div_last) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_last) begin
          state_d = ST_GAP;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          rx_q_d  = rx_shift;
        end
      end
      ST_GAP: begin
        if (div_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_q     <= '0;
      grant_q  <= '0;
      sclk_q   <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      bit_cnt  <= bit_d;
      tx_shift <= tx_d;
      rx_shift <= rx_d;
      rx_q     <= rx_q_d;
      grant_q  <= grant_d;
      sclk_q   <= sclk_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: SPI slave model plus a transfer-level
// reference (arbitration rule, expected bytes, timing) driven by directed and random requests.
module tb_spi_master_arbiter;

  localparam int NR     = 3;
  localparam int DIV    = 2;
  localparam int DW     = 8;
  localparam int TW     = NR * DW;
  localparam int SS_LOW = (2 * DW + 1) * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req;
  logic [TW-1:0] req_data;
  logic [NR-1:0] grant;
  logic          done;
  logic [DW-1:0] rx_data;
  logic          busy, SCLK, MOSI, SS;
  logic          MISO = 1'b0;

  logic [1:0]      req2, grant2;
  logic [2*DW-1:0] req_data2;
  logic            done2, busy2, sclk2, mosi2, ss2, miso2;
  logic [DW-1:0]   rx2;

  int            checks = 0;
  int            errors = 0;
  int            model_ptr = 0;
  int            done_count = 0;
  int            sl_rises = 0;
  logic [DW-1:0] prev_rx = '0;
  logic [DW-1:0] slave_byte = '0;
  logic [DW-1:0] sl_shift = '0;
  logic [DW-1:0] sl_rx = '0;
  logic          last_ss = 1'b1;
  logic          last_sclk = 1'b0;

  spi_master_arbiter #(.NUM_REQ(NR), .CLK_DIV(DIV), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
    .rx_data(rx_data), .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
  );

  spi_master_arbiter #(.NUM_REQ(2), .CLK_DIV(1), .DATA_W(DW)) dut_fast (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .grant(grant2), .done(done2),
    .rx_data(rx2), .busy(busy2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2), .SS(ss2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_count <= done_count + 1;
  end

  // Mode-0 slave: loads its reply when SS falls, samples MOSI on SCLK rise, shifts MISO on fall.
  always @(SS or SCLK) begin
    if (SS === 1'b0 && last_ss === 1'b1) begin
      sl_shift = slave_byte;
      sl_rx    = '0;
      sl_rises = 0;
      MISO     = slave_byte[DW-1];
    end else if (SS === 1'b0 && SCLK === 1'b1 && last_sclk === 1'b0) begin
      sl_rx = {sl_rx[DW-2:0], MOSI};
      sl_rises++;
    end else if (SS === 1'b0 && SCLK === 1'b0 && last_sclk === 1'b1) begin
      sl_shift = {sl_shift[DW-2:0], 1'b0};
      MISO     = sl_shift[DW-1];
    end
    last_ss   = SS;
    last_sclk = SCLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickWinner(input logic [NR-1:0] r);
`ifdef SPI_ARB_RR_EN
    for (int k = 0; k < NR; k++) begin
      if (r[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
    end
`else
    for (int k = 0; k < NR; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ss", 32'(SS), 32'd1);
    checkOutput("rst_sclk", 32'(SCLK), 32'd0);
    checkOutput("rst_mosi", 32'(MOSI), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rx", 32'(rx_data), 32'd0);
    rst       = 1'b0;
    model_ptr = 0;
    prev_rx   = '0;
  endtask

  task automatic waitIdle();
    int t;
    req = '0;
    t   = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("idle_reached", 32'(t < 100), 32'd1);
  endtask

  // One transfer: drive requests, then check grant, MOSI byte, rx byte, timing and rx hold.
  task automatic applyStimulus(input logic [NR-1:0] r, input logic [TW-1:0] d,
                               input logic [DW-1:0] sb, input int mid);
    int            w, t, c, ss_low;
    logic          rx_held;
    logic [DW-1:0] exp_tx;
    req        = r;
    req_data   = d;
    slave_byte = sb;
    t = 0;
    while (SS !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("ss_fall", 32'(t < 200), 32'd1);
    if (t >= 200) return;
    w = pickWinner(r);
`ifdef SPI_ARB_RR_EN
    model_ptr = (w + 1) % NR;
`endif
    exp_tx = DW'(d >> (w * DW));
    checkOutput("grant", 32'(grant), 32'd1 << w);
    checkOutput("busy", 32'(busy), 32'd1);
    ss_low  = 1;
    c       = 0;
    rx_held = 1'b1;
    while (done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
      if (SS === 1'b0) ss_low++;
      if (done !== 1'b1 && rx_data !== prev_rx) rx_held = 1'b0;
      if (mid != 0 && c == mid) begin
        req_data = ~d;
        req      = '0;
      end
    end
    checkOutput("done_latency", 32'(c + 1), 32'(SS_LOW + 1));
    checkOutput("ss_low_cycles", 32'(ss_low), 32'(SS_LOW));
    checkOutput("rx_data", 32'(rx_data), 32'(sb));
    checkOutput("mosi_byte", 32'(sl_rx), 32'(exp_tx));
    checkOutput("sclk_rises", 32'(sl_rises), 32'(DW));
    checkOutput("rx_hold", 32'(rx_held), 32'd1);
    prev_rx = sb;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic resetMidTransfer();
    int t, dc;
    req        = 3'b001;
    req_data   = 24'h00005A;
    slave_byte = 8'hC3;
    t = 0;
    while ((SS !== 1'b0 || sl_rises < 4) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rst_mid_reach", 32'(t < 200), 32'd1);
    dc = done_count;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_ss", 32'(SS), 32'd1);
    checkOutput("rst_mid_sclk", 32'(SCLK), 32'd0);
    checkOutput("rst_mid_grant", 32'(grant), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    model_ptr = 0;
    prev_rx   = '0;
    checkOutput("rst_mid_no_done", 32'(done_count - dc), 32'd0);
    checkOutput("rst_mid_rx", 32'(rx_data), 32'd0);
    applyStimulus(3'b001, 24'h00005A, 8'hC3, 0);
  endtask

  // CLK_DIV=1 instance with req held: SS gap, phase widths and byte on the wire.
  task automatic checkFastDivider();
    int            t, h, l, hi;
    logic          prev_s, adj, busy_bad;
    logic [DW-1:0] wire_byte;
    t = 0;
    while (ss2 !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    while (ss2 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    checkOutput("fast_sync", 32'(t < 100), 32'd1);
    h = 0;
    while (ss2 === 1'b1 && h < 20) begin @(negedge clk); h++; end
    checkOutput("fast_ss_high", 32'(h), 32'd2);
    l = 0; hi = 0; adj = 1'b0; prev_s = 1'b0; busy_bad = 1'b0; wire_byte = '0;
    while (ss2 === 1'b0 && l < 100) begin
      l++;
      if (sclk2 === 1'b1) begin
        hi++;
        wire_byte = {wire_byte[DW-2:0], mosi2};
        if (prev_s) adj = 1'b1;
      end
      if (busy2 !== 1'b1 || grant2 !== 2'b01) busy_bad = 1'b1;
      prev_s = sclk2;
      @(negedge clk);
    end
    checkOutput("fast_ss_low", 32'(l), 32'(2 * DW + 1));
    checkOutput("fast_sclk_high", 32'(hi), 32'(DW));
    checkOutput("fast_sclk_phase", 32'(adj), 32'd0);
    checkOutput("fast_busy_grant", 32'(busy_bad), 32'd0);
    checkOutput("fast_mosi_byte", 32'(wire_byte), 32'hC3);
    checkOutput("fast_done", 32'(done2), 32'd1);
    checkOutput("fast_rx", 32'(rx2), 32'd0);
  endtask

  initial begin
    int            dc;
    logic [NR-1:0] r;
    req       = '0;
    req_data  = '0;
    req2      = 2'b01;
    req_data2 = 16'h00C3;
    miso2     = 1'b0;
    #1;
    doReset();

    applyStimulus(3'b001, 24'h0000A5, 8'h3C, 0);
    waitIdle();

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(3'b011, 24'h002211, DW'($urandom), 0);
    waitIdle();

    dc = done_count;
    applyStimulus(3'b100, 24'hF00000, 8'h96, 10);
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("mid_done_once", 32'(done_count - dc), 32'd1);
    checkOutput("mid_idle_grant", 32'(grant), 32'd0);
    checkOutput("mid_idle_ss", 32'(SS), 32'd1);

    applyStimulus(3'b001, TW'($urandom), 8'hFF, 0);
    applyStimulus(3'b010, TW'($urandom), 8'h00, 0);
    waitIdle();

    resetMidTransfer();
    waitIdle();

    for (int i = 0; i < 12; i++) begin
      r = NR'($urandom_range(1, (1 << NR) - 1));
      applyStimulus(r, TW'($urandom), DW'($urandom), 0);
      if ($urandom_range(0, 1) == 1) waitIdle();
    end
    waitIdle();

    checkFastDivider();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
